// File: rtl/zimbo_pkg.sv
// Shared Zimbo memory-arbiter definitions: bus widths, arbiter states, port indices.
package zimbo_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/zimbo_rr_pick.sv
// Combinational 2-way round-robin picker: on contention the port not granted last wins.
module zimbo_rr_pick
    import zimbo_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req0 && req1) begin
            if (last == PORT_LDR) gnt[PORT_CPU] = 1'b1;
            else                  gnt[PORT_LDR] = 1'b1;
        end else begin
            gnt[PORT_CPU] = req0;
            gnt[PORT_LDR] = req1;
        end
    end

endmodule

// File: rtl/zimbo_mem_arbiter.sv
// Two-port round-robin arbiter for the single-port Zimbo data memory (CPU vs loader).
// Optional per-port bus locking is compiled in with ZIMBO_ARB_LOCK_EN.
module zimbo_mem_arbiter #(
    parameter int AW = zimbo_pkg::AW,
    parameter int DW = zimbo_pkg::DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] addrm,
    output logic [DW-1:0] wmdata,
    output logic          memwr_en,
    input  logic [DW-1:0] rmdata
);

    import zimbo_pkg::*;

    arb_state_t state, state_d;
    logic       last, last_d;
    logic       rd_pend0, rd_pend1;
    logic [1:0] pick;
    logic       lk0, lk1;

`ifdef ZIMBO_ARB_LOCK_EN
    assign lk0 = lock0;
    assign lk1 = lock1;
`else
    // Locks tied off: the FSM can never leave IDLE.
    logic unused_lock;
    assign lk0 = 1'b0;
    assign lk1 = 1'b0;
    assign unused_lock = lock0 ^ lock1;
`endif

    zimbo_rr_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .gnt  (pick)
    );

    // Grants are gated by reset so the bus is quiet while reset_n is low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            case (state)
                ARB_OWN0: gnt0 = req0;
                ARB_OWN1: gnt1 = req1;
                default: begin
                    gnt0 = pick[PORT_CPU];
                    gnt1 = pick[PORT_LDR];
                end
            endcase
        end
    end

    always_comb begin
        state_d = state;
        last_d  = last;
        case (state)
            ARB_IDLE: begin
                if (gnt0) begin
                    if (lk0) state_d = ARB_OWN0;
                    else     last_d  = PORT_CPU;
                end else if (gnt1) begin
                    if (lk1) state_d = ARB_OWN1;
                    else     last_d  = PORT_LDR;
                end
            end
            ARB_OWN0: begin
                if (!lk0) begin
                    state_d = ARB_IDLE;
                    if (req0) last_d = PORT_CPU;
                end
            end
            ARB_OWN1: begin
                if (!lk1) begin
                    state_d = ARB_IDLE;
                    if (req1) last_d = PORT_LDR;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        addrm    = '0;
        wmdata   = '0;
        memwr_en = 1'b0;
        if (gnt0) begin
            addrm    = addr0;
            wmdata   = wdata0;
            memwr_en = we0;
        end else if (gnt1) begin
            addrm    = addr1;
            wmdata   = wdata1;
            memwr_en = we1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            last     <= PORT_LDR;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            state    <= state_d;
            last     <= last_d;
            rd_pend0 <= gnt0 & ~we0;
            rd_pend1 <= gnt1 & ~we1;
        end
    end

    assign rvalid0 = rd_pend0;
    assign rvalid1 = rd_pend1;
    assign rdata   = rmdata;

endmodule

// File: doc/zimbo_mem_arbiter.md
# zimbo_mem_arbiter

Two-port arbiter that shares the single-port Zimbo data memory (16-bit address, 16-bit data, synchronous read) between the CPU core and a debug/program loader port. Sits between `zimbotop`'s memory bus and `memory`: each requester sees a request/grant handshake plus a read-valid strobe, and the arbiter drives `addrm`, `wmdata` and `memwr_en` and forwards `rmdata`. Arbitration is round-robin, with an optional per-port lock that holds ownership for multi-access sequences.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `clock` in 1: sole clock; all state changes on its rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req0`, `req1` in 1: access request, ports 0 (CPU) and 1 (loader)
- `we0`, `we1` in 1: 1 = write, 0 = read; qualified by `reqN`
- `addr0`, `addr1` in AW: access address
- `wdata0`, `wdata1` in DW: write data
- `lock0`, `lock1` in 1: hold ownership after the current grant (honoured only with `ZIMBO_ARB_LOCK_EN`)
- `gnt0`, `gnt1` out 1: access accepted this cycle
- `rvalid0`, `rvalid1` out 1: `rdata` holds read data for that port
- `rdata` out DW: shared read data, equal to `rmdata`
- `addrm` out AW, `wmdata` out DW, `memwr_en` out 1: memory command
- `rmdata` in DW: memory read data, valid one cycle after the address

## Operation
- Handshake: the requester holds `reqN`, `weN`, `addrN`, `wdataN` stable until it samples `gntN` = 1 at a rising edge. One access per `gntN` cycle. Back-to-back accesses are allowed: keep `reqN` high with new fields after the grant.
- `gntN` is combinational from `reqN` and the registered arbitration state. At most one `gnt` is high per cycle.
- In a granted cycle, `addrm`, `wmdata` and `memwr_en` (= `weN`) are muxed from the winner. With no grant they are 0.
- FSM (`state`): IDLE, OWN0, OWN1.
  - IDLE: round-robin on `last` (1 bit). Priority goes to the port not granted most recently. A single requester wins immediately.
  - Grant to port N with `lockN` = 1 → OWNN. Otherwise stay IDLE and set `last` = N.
  - OWNN: only port N may be granted. Port 1−N waits even if port N is idle.
  - OWNN exits to IDLE at the first edge where `reqN` = 1, `gntN` = 1 and `lockN` = 0. At that edge `last` = N.
  - OWNN also exits to IDLE at any edge where `reqN` = 0 and `lockN` = 0.
- Read return: on a read grant, register `rd_pendN` ← 1. Next cycle `rvalidN` = 1 and `rdata` = `rmdata`. `rvalidN` is a one-cycle pulse per read and is 0 after writes.
- A write followed by a read to the same address returns the new data (memory write-first at the edge).

## Timing
- Grant latency: 0 cycles when uncontested. A contested loser waits 1 access. A requester waits a full locked sequence if the other port owns the bus.
- Read latency: `rvalidN` exactly 1 cycle after the `gntN` cycle. Throughput is 1 access/cycle.
- Simultaneous `req0` & `req1` in IDLE after reset: port 0 wins (reset `last` = 1).
- Requests dropped before grant are not an error and leave no state.
- Reset values:
  - `state` = IDLE, `last` = 1, `rd_pend0/1` = 0.
  - Hence `gnt0/1`, `rvalid0/1`, `memwr_en`, `addrm`, `wmdata` = 0 while `reset_n` = 0.
- Reset asserted mid-operation:
  - An in-flight read's `rvalid` is dropped.
  - Ownership is released.
  - A write in the granted cycle is not guaranteed.

## Configuration
- `ZIMBO_ARB_LOCK_EN` defined: OWN0/OWN1 states and lock behaviour as above.
- Not defined: `lock0`/`lock1` are ignored, the FSM never leaves IDLE, and arbitration is pure round-robin per access. Ports are identical in both builds.

## Structure
- Shared package `zimbo_pkg`:
  - `AW`/`DW` defaults
  - arbiter state enum constants (`ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`)
  - port index constants `PORT_CPU` = 0, `PORT_LDR` = 1
- One natural sub-module: `zimbo_rr_pick`, a combinational 2-way round-robin picker (inputs `req0`, `req1`, `last`; output one-hot grant). The FSM, mux and read-pending registers stay in the top.

## Test plan
- Reset, then idle: all outputs 0. Release reset with `req0` = `req1` = 1, both reads → `gnt0` in cycle 1, `gnt1` in cycle 2, `rvalid0` in cycle 2, `rvalid1` in cycle 3.
- Port 1 writes 0xBEEF at 0x0040, then port 0 reads 0x0040 → `memwr_en` = 1 with `addrm` = 0x0040 in the write cycle; `rvalid0` with `rdata` = 0xBEEF one cycle after `gnt0`.
- Both ports request continuously for 8 cycles → grants alternate 0, 1, 0, 1…; 4 grants each; never both high.
- `ZIMBO_ARB_LOCK_EN`: port 1 locks and makes 3 writes while port 0 requests → `gnt1` × 3 consecutive, `gnt0` 0. After `lock1` drops on the third access, `gnt0` is high the next cycle.
- Without `ZIMBO_ARB_LOCK_EN`, same stimulus → alternating grants; locks ignored.
- Assert `reset_n` = 0 the cycle after a port-0 read grant → `rvalid0` stays 0. After release, the first contested grant goes to port 0.
